// File: rtl/wb_queue.sv
// wb_queue: register write-back queue feeding the register file's single write port.
// Requests are accepted over valid/ready, buffered in order in a circular buffer,
// and drained one per cycle into a registered reg_wr/wr_num/wr_data port.
// Optional feature macro: WB_BYPASS_EN builds the combinational bypass lookup;
// without it, lk_hit1/2 and lk_data1/2 are tied to zero.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_num,
  input  logic [31:0]                in_data,
  input  logic                       drain_en,
  output logic                       reg_wr,
  output logic [4:0]                 wr_num,
  output logic [31:0]                wr_data,
  input  logic [4:0]                 lk_num1,
  input  logic [4:0]                 lk_num2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [31:0]                lk_data1,
  output logic [31:0]                lk_data2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  // Queue storage and pointers
  logic [4:0]    num_q  [DEPTH];
  logic [4:0]    num_d  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Output register toward the register file
  logic          reg_wr_q, reg_wr_d;
  logic [4:0]    wr_num_q, wr_num_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic          full_s;
  logic          empty_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;

  assign full_s   = (count_q == CNT_FULL);
  assign empty_s  = (count_q == {CW{1'b0}});
  // Ready depends only on occupancy; no pass-through when full.
  assign in_ready = ~full_s & ~rst;
  assign accept_s = in_valid & in_ready;
  // Writes to r0 are accepted but never stored or issued.
  assign push_s   = accept_s & (in_num != 5'd0);
  assign pop_s    = ~empty_s & drain_en;

  assign count   = count_q;
  assign full    = full_s;
  assign empty   = empty_s;
  assign reg_wr  = reg_wr_q;
  assign wr_num  = wr_num_q;
  assign wr_data = wr_data_q;

  // Next-state for storage, pointers, occupancy and the output register
  always_comb begin
    num_d     = num_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    reg_wr_d  = 1'b0;
    wr_num_d  = wr_num_q;
    wr_data_d = wr_data_q;

    if (push_s) begin
      num_d[tail_q]  = in_num;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      reg_wr_d  = 1'b1;
      wr_num_d  = num_q[head_q];
      wr_data_d = data_q[head_q];
      head_d    = head_q + PTR_ONE;
    end else begin
      reg_wr_d  = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset discarding all pending entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        num_q[i]  <= 5'd0;
        data_q[i] <= 32'd0;
      end
      head_q    <= {PW{1'b0}};
      tail_q    <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      reg_wr_q  <= 1'b0;
      wr_num_q  <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      num_q     <= num_d;
      data_q    <= data_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      reg_wr_q  <= reg_wr_d;
      wr_num_q  <= wr_num_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass lookup: output register lowest priority, then queue oldest to youngest,
  // later matches override earlier ones so the youngest pending value wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = head_q;
    lk_hit1  = 1'b0;
    lk_data1 = 32'd0;
    lk_hit2  = 1'b0;
    lk_data2 = 32'd0;

    if (reg_wr_q && (wr_num_q == lk_num1)) begin
      lk_hit1  = 1'b1;
      lk_data1 = wr_data_q;
    end else begin
      lk_hit1  = 1'b0;
    end
    if (reg_wr_q && (wr_num_q == lk_num2)) begin
      lk_hit2  = 1'b1;
      lk_data2 = wr_data_q;
    end else begin
      lk_hit2  = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + i[PW-1:0];
      if (i < int'(count_q)) begin
        if (num_q[idx] == lk_num1) begin
          lk_hit1  = 1'b1;
          lk_data1 = data_q[idx];
        end else begin
          lk_hit1  = lk_hit1;
        end
        if (num_q[idx] == lk_num2) begin
          lk_hit2  = 1'b1;
          lk_data2 = data_q[idx];
        end else begin
          lk_hit2  = lk_hit2;
        end
      end else begin
        idx = head_q;
      end
    end

    // r0 is never pending
    if (lk_num1 == 5'd0) begin
      lk_hit1  = 1'b0;
      lk_data1 = 32'd0;
    end else begin
      lk_hit1  = lk_hit1;
    end
    if (lk_num2 == 5'd0) begin
      lk_hit2  = 1'b0;
      lk_data2 = 32'd0;
    end else begin
      lk_hit2  = lk_hit2;
    end
  end
`else
  logic unused_lk_num;
  assign unused_lk_num = ^{lk_num1, lk_num2};
  assign lk_hit1  = 1'b0;
  assign lk_hit2  = 1'b0;
  assign lk_data1 = 32'd0;
  assign lk_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus randomized traffic,
// compared every cycle against a queue-level reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_num = 5'd0;
  logic [31:0]   in_data = 32'd0;
  logic          drain_en = 1'b0;
  logic          reg_wr;
  logic [4:0]    wr_num;
  logic [31:0]   wr_data;
  logic [4:0]    lk_num1 = 5'd0;
  logic [4:0]    lk_num2 = 5'd0;
  logic          lk_hit1, lk_hit2;
  logic [31:0]   lk_data1, lk_data2;
  logic [CW-1:0] count;
  logic          full, empty;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending writes in acceptance order, plus the output port
  logic [36:0] mq[$];
  logic        m_wr   = 1'b0;
  logic [4:0]  m_num  = 5'd0;
  logic [31:0] m_data = 32'd0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_data(in_data),
    .drain_en(drain_en),
    .reg_wr(reg_wr), .wr_num(wr_num), .wr_data(wr_data),
    .lk_num1(lk_num1), .lk_num2(lk_num2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Youngest pending value for a register, searching the queue newest-first,
  // then the value currently on the write port.
  function automatic logic [32:0] exp_lk(input logic [4:0] k);
    logic [32:0] r;
    logic        found;
    r = 33'd0;
    found = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!found && mq[i][36:32] == k) begin
        r = {1'b1, mq[i][31:0]};
        found = 1'b1;
      end
    end
    if (!found && m_wr && m_num == k) r = {1'b1, m_data};
    if (k == 5'd0) r = 33'd0;
`ifndef WB_BYPASS_EN
    r = 33'd0;
`endif
    return r;
  endfunction

  task automatic check_all();
    logic [32:0] e1, e2;
    int          sz;
    sz = mq.size();
    e1 = exp_lk(lk_num1);
    e2 = exp_lk(lk_num2);
    check("in_ready", 64'(in_ready), 64'(!rst && sz < DEPTH));
    check("count",    64'(count),    64'(sz));
    check("full",     64'(full),     64'(sz == DEPTH));
    check("empty",    64'(empty),    64'(sz == 0));
    check("reg_wr",   64'(reg_wr),   64'(m_wr));
    check("wr_num",   64'(wr_num),   64'(m_num));
    check("wr_data",  64'(wr_data),  64'(m_data));
    check("lk_hit1",  64'(lk_hit1),  64'(e1[32]));
    check("lk_data1", 64'(lk_data1), 64'(e1[31:0]));
    check("lk_hit2",  64'(lk_hit2),  64'(e2[32]));
    check("lk_data2", 64'(lk_data2), 64'(e2[31:0]));
  endtask

  // Advance the model by the edge that follows the current inputs
  task automatic model_step();
    logic acc;
    if (rst) begin
      mq.delete();
      m_wr = 1'b0; m_num = 5'd0; m_data = 32'd0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      if (drain_en && mq.size() > 0) begin
        m_wr = 1'b1;
        m_num = mq[0][36:32];
        m_data = mq[0][31:0];
        void'(mq.pop_front());
      end else begin
        m_wr = 1'b0;
      end
      if (acc && in_num != 5'd0) mq.push_back({in_num, in_data});
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [4:0] n, input logic [31:0] d,
                       input logic de, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; in_valid = v; in_num = n; in_data = d; drain_en = de;
    lk_num1 = a; lk_num2 = b;
    #1;
    check_all();
    model_step();
  endtask

  initial begin
    // Reset
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    // Single write, minimum latency
    cycle(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 5'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd4);
    // Fill with drain stalled, fifth held, then drain
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b1, 5'(i), 32'(i * 17), 1'b0, 5'd2, 5'd4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd1, 5'd5);
    cycle(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd1, 5'd5);
    cycle(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd1, 5'd5);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd5);
    // Bypass: youngest same-register write wins
    cycle(1'b0, 1'b1, 5'd5, 32'd1, 1'b0, 5'd5, 5'd6);
    cycle(1'b0, 1'b1, 5'd5, 32'd2, 1'b0, 5'd5, 5'd6);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
    // r0 write accepted and discarded
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd1);
    // Reset discards pending entries
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 5'd11, 5'd12);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd11, 5'd12);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd12);
    // Simultaneous push and pop at count 2
    cycle(1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd7, 5'd8);
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd7, 5'd9);
    cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd9);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)),
            32'($urandom()),
            ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
